// File: rtl/simon_core_param.sv
// Iterative SIMON 2N/MN block-cipher engine: one-time key expansion into a round-key
// buffer, then RPC rounds per clock for encryption or decryption of blocks.
module simon_core_param #(
  parameter int N   = 48,
  parameter int M   = 3,
  parameter int T   = 54,
  parameter int Z   = 3,
  parameter int RPC = 1
) (
  input  logic           clk,
  input  logic           R,
  input  logic           newKey,
  input  logic [M*N-1:0] KEY,
  output logic           loadKey,
  output logic           doneKey,
  input  logic           newData,
  input  logic [2*N-1:0] blockIN,
  input  logic           enc_dec,
  output logic           loadData,
  output logic           doneData,
  input  logic           readData,
  output logic [2*N-1:0] outData,
  output logic           busy
);

  localparam int IW = (T > 1) ? $clog2(T) : 1;
  localparam logic [IW-1:0] KEXP_LAST = IW'(T - M - 1);
  localparam logic [IW-1:0] RUN_LAST  = IW'(T - RPC);
  localparam logic [IW-1:0] RPC_STEP  = IW'(RPC);

  generate
    if ((RPC < 1) || (T % RPC != 0)) begin : gBadRpc
      $error("simon_core_param: T must be a positive multiple of RPC");
    end
    if ((Z < 0) || (Z > 4)) begin : gBadZ
      $error("simon_core_param: Z must be in 0..4");
    end
    if ((M < 2) || (M > 4) || (T <= M)) begin : gBadM
      $error("simon_core_param: M must be 2..4 and T greater than M");
    end
  endgenerate

  // z sequences written left to right, so bit i of the sequence lives at [61-i]
  function automatic logic [61:0] zTable(input int sel);
    case (sel)
      0:       zTable = 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       zTable = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       zTable = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       zTable = 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: zTable = 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  localparam logic [61:0] ZSEQ = zTable(Z);

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    rol = (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    ror = (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] fRound(input logic [N-1:0] x);
    fRound = (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
  endfunction

  typedef enum logic [1:0] {IDLE, KEXP, RUN, HOLD} state_t;

  state_t        state, stateNext;
  logic          acceptKey, acceptData, kexpLast, runLast;
  logic [IW-1:0] kIdx, kPtr;
  logic [N-1:0]  rk [0:T-1];
  logic [N-1:0]  kNew;
  logic          zBit;
  logic [N-1:0]  curX, curY, nextX, nextY;
  logic          encMode;

  always_ff @(posedge clk or posedge R) begin
    if (R) state <= IDLE;
    else   state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    acceptKey  = 1'b0;
    acceptData = 1'b0;
    kexpLast   = 1'b0;
    runLast    = 1'b0;
    case (state)
      IDLE: begin
        if (newKey) begin
          acceptKey = 1'b1;
          stateNext = KEXP;
        end else if (newData && doneKey && !doneData) begin
          acceptData = 1'b1;
          stateNext  = RUN;
        end
      end
      KEXP: begin
        if (kIdx == KEXP_LAST) begin
          kexpLast  = 1'b1;
          stateNext = IDLE;
        end
      end
      RUN: begin
        if (kPtr == RUN_LAST) begin
          runLast   = 1'b1;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (readData) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Key schedule: derive k[kIdx+M] from k[kIdx], k[kIdx+1] and k[kIdx+M-1]
  always_comb begin
    logic [N-1:0] tmp;
    zBit = ZSEQ[6'(61 - (int'(kIdx) % 62))];
    tmp  = ror(rk[kIdx + IW'(M - 1)], 3);
    if (M == 4) tmp = tmp ^ rk[kIdx + IW'(1)];
    tmp  = tmp ^ ror(tmp, 1);
    kNew = ~rk[kIdx] ^ tmp ^ {{(N-1){1'b0}}, zBit} ^ N'(3);
  end

  // Unrolled round chain; decryption walks the schedule from the top down
  always_comb begin
    logic [N-1:0] a, b, t, rkey;
    int           e;
    a    = curX;
    b    = curY;
    t    = '0;
    rkey = '0;
    e    = 0;
    for (int j = 0; j < RPC; j++) begin
      e    = int'(kPtr) + j;
      rkey = encMode ? rk[IW'(e)] : rk[IW'(T - 1 - e)];
      t    = a;
      a    = b ^ fRound(a) ^ rkey;
      b    = t;
    end
    nextX = a;
    nextY = b;
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      loadKey  <= 1'b0;
      doneKey  <= 1'b0;
      loadData <= 1'b0;
      doneData <= 1'b0;
      kIdx     <= '0;
      kPtr     <= '0;
      outData  <= '0;
    end else begin
      loadKey  <= acceptKey;
      loadData <= acceptData;
      if (acceptKey) begin
        doneKey <= 1'b0;
        kIdx    <= '0;
      end else if (state == KEXP) begin
        if (kexpLast) doneKey <= 1'b1;
        else          kIdx    <= kIdx + IW'(1);
      end
      if (acceptData)
        kPtr <= '0;
      else if ((state == RUN) && !runLast)
        kPtr <= kPtr + RPC_STEP;
      if (runLast) begin
        doneData <= 1'b1;
        outData  <= encMode ? {nextX, nextY} : {nextY, nextX};
      end else if ((state == HOLD) && readData) begin
        doneData <= 1'b0;
      end
    end
  end

  // Datapath storage: round-key buffer and working halves carry no reset
  always_ff @(posedge clk) begin
    if (acceptKey) begin
      for (int m = 0; m < M; m++) rk[IW'(m)] <= KEY[m*N +: N];
    end else if (state == KEXP) begin
      rk[kIdx + IW'(M)] <= kNew;
    end
    if (acceptData) begin
      encMode <= enc_dec;
      if (enc_dec) begin
        curX <= blockIN[2*N-1:N];
        curY <= blockIN[N-1:0];
      end else begin
        curX <= blockIN[N-1:0];
        curY <= blockIN[2*N-1:N];
      end
    end else if (state == RUN) begin
      curX <= nextX;
      curY <= nextY;
    end
  end

endmodule

// File: doc/simon_core_param.md
Name: simon_core_param

Overview:
Generic iterative SIMON block-cipher engine covering all ten SIMON variants (2N/MN) through parameters. It expands the key once into an internal round-key buffer, then encrypts or decrypts any number of blocks against that schedule. RPC rounds execute per clock. It replaces the per-variant cores and keeps the newData/loadData/doneData/readData and newKey/loadKey/doneKey handshake toward the host controller.

Parameters:
N, 48, word size in bits (16, 24, 32, 48, 64); block is 2N.
M, 3, key words (2, 3, 4); key is M*N.
T, 54, total rounds; T mod RPC must be 0, otherwise elaboration fails.
Z, 3, z-sequence select 0..4 (per SIMON spec: 32/64 and 48/72 use 0; 48/96 uses 1; 64/96, 96/96 and 128/128 use 2; 64/128, 96/144 and 128/192 use 3; 128/256 uses 4).
RPC, 1, rounds per clock in the datapath (unroll factor).

Ports:
clk  in  1  clock, all state changes on the rising edge
R  in  1  asynchronous active-high reset
newKey  in  1  level request: KEY is valid
KEY  in  M*N  key; [N-1:0]=k0, up to k(M-1) in the MSBs
loadKey  out  1  one-cycle pulse: KEY captured
doneKey  out  1  level: full schedule ready
newData  in  1  level request: blockIN is valid
blockIN  in  2N  [2N-1:N]=x (left), [N-1:0]=y (right)
enc_dec  in  1  1=encrypt, 0=decrypt; sampled with blockIN
loadData  out  1  one-cycle pulse: block captured
doneData  out  1  level: outData valid
readData  in  1  host has consumed outData
outData  out  2N  result, same half ordering as blockIN
busy  out  1  high when the FSM is not IDLE

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. loadKey, doneKey, loadData, doneData and busy are 0. outData is 0. The round-key buffer is marked invalid and its contents are undefined.
- FSM states: IDLE, KEXP, RUN, HOLD.
- IDLE + newKey=1 at an edge:
  - KEY is written into slots 0..M-1 of the T-entry buffer.
  - loadKey pulses for 1 cycle; doneKey clears.
  - The FSM moves to KEXP.
- KEXP generates one round key per edge, for i = 0..T-M-1:
  - tmp = ror3(k[i+M-1]).
  - If M=4, tmp ^= k[i+1].
  - tmp ^= ror1(tmp).
  - k[i+M] = ~k[i] ^ tmp ^ z_Z[i mod 62] ^ 3.
  - After T-M edges, doneKey is set and the FSM returns to IDLE.
- IDLE + newKey=0 + newData=1 + doneKey=1 + doneData=0 at an edge:
  - The block is captured. Decrypt swaps x and y on entry.
  - enc_dec is latched; loadData pulses for 1 cycle.
  - The round counter is cleared and the FSM moves to RUN.
- newData while doneKey=0 or doneData=1 is not accepted. The request stays pending and loadData is not pulsed.
- newKey and newData both high in IDLE: newKey wins.
- Neither request is sampled outside IDLE. Both are level-held, so the host keeps them asserted until the matching load pulse.
- RUN applies RPC rounds per edge: (x,y) -> (y ^ f(x) ^ k, x), with f(x) = (rol1 x & rol8 x) ^ rol2 x.
  - Encrypt uses keys k[r], r ascending from 0.
  - Decrypt uses keys k[T-1-r] and swaps the halves on exit.
- Latency: doneData rises exactly T/RPC edges after the edge that raised loadData. At that edge outData is written and the FSM moves to HOLD. Example: 96/144 with RPC=1 takes 54 cycles.
- HOLD: outData and doneData are held while readData=0. At the first edge with readData=1, doneData clears and the FSM returns to IDLE. outData keeps its value until the next completion.
- readData=1 outside HOLD is ignored.
- A new key is accepted only after the current result has been read. The schedule is never overwritten mid-RUN.
- Arithmetic: all rotates are modulo N and all words are N bits. The z bit is LSB-aligned and XORed into bit 0 only. The constant 3 is ...0011.
- Rotate direction: ror in the key schedule, rol in f.

Test Plan:
- 32/64 (N=16, M=4, T=32, Z=0): KEY=1918_1110_0908_0100, encrypt 6565_6877 -> outData c69b_e9bb. doneKey 28 cycles after loadKey; doneData 32 cycles after loadData.
- 96/144 (N=48, M=3, T=54, Z=3): KEY=151413121110_0d0c0b0a0908_050403020100, encrypt 74616874207473756420666f -> ecad1c6c451e3f59c5db1ae9. Decrypting that result returns the plaintext.
- 64/128 with RPC=4: KEY=1b1a1918_13121110_0b0a0908_03020100, pt 656b696c_20646e75 -> ct 44c8fc20_b9dfa07a. doneData exactly 11 cycles after loadData.
- Back-pressure: hold readData=0 for 20 cycles after doneData with newData=1. No loadData pulse and outData stays stable; after readData, doneData falls, then exactly one loadData pulse follows.
- Simultaneous newKey+newData in IDLE: loadKey pulses and loadData does not. The block is processed only after doneKey, using the new key.
- R asserted mid-RUN (round 10) and mid-KEXP: every output is 0 immediately (asynchronous). newData after reset does not load until a new key has been expanded.
